// File: rtl/apu_i2s_tx.sv
// Philips I2S transmitter for the APU mixer output: 16-bit mono sample sent on both
// channels, 32 BCLK per frame, with offset-binary conversion, attenuation and mute.
module apu_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [15:0] sample_i,
    input  logic [2:0]  vol_shift_i,
    input  logic        mute_i,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        sdata_o,
    output logic        sample_strobe_o
);

    localparam int            DW       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0]      div_cnt, div_cnt_nxt;
    logic [4:0]         slot, slot_nxt;
    logic [15:0]        shreg, shreg_nxt;
    logic [15:0]        word, word_nxt;
    logic               bclk_nxt, lrclk_nxt, sdata_nxt, strobe_nxt;
    logic               div_wrap, fall_edge;
    logic signed [15:0] conv, atten;
    logic [15:0]        processed;

    assign div_wrap  = (div_cnt == DIV_LAST);
    assign fall_edge = div_wrap & bclk_o;

    // Flipping the MSB turns offset binary into two's complement; the shift keeps sign.
    assign conv      = {~sample_i[15], sample_i[14:0]};
    assign atten     = conv >>> vol_shift_i;
    assign processed = mute_i ? 16'h0000 : atten;

    always_comb begin
        div_cnt_nxt = div_cnt;
        slot_nxt    = slot;
        shreg_nxt   = shreg;
        word_nxt    = word;
        bclk_nxt    = bclk_o;
        lrclk_nxt   = lrclk_o;
        sdata_nxt   = sdata_o;
        strobe_nxt  = 1'b0;

        if (!enable_i) begin
            div_cnt_nxt = '0;
            slot_nxt    = 5'd31;
            shreg_nxt   = '0;
            word_nxt    = '0;
            bclk_nxt    = 1'b0;
            lrclk_nxt   = 1'b0;
            sdata_nxt   = 1'b0;
        end else begin
            div_cnt_nxt = div_wrap ? '0 : div_cnt + DW'(1);
            if (div_wrap)
                bclk_nxt = ~bclk_o;
            // Everything visible to the DAC moves on the BCLK falling edge only.
            if (fall_edge) begin
                slot_nxt  = slot + 5'd1;
                lrclk_nxt = slot_nxt[4];
                if (slot_nxt == 5'd0) begin
                    word_nxt   = processed;
                    strobe_nxt = 1'b1;
                end
                // Load one slot after each LRCLK edge to give the I2S one-bit delay.
                if (slot_nxt[3:0] == 4'd1)
                    shreg_nxt = word;
                else
                    shreg_nxt = {shreg[14:0], 1'b0};
                sdata_nxt = shreg_nxt[15];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt         <= '0;
            slot            <= 5'd31;
            shreg           <= '0;
            word            <= '0;
            bclk_o          <= 1'b0;
            lrclk_o         <= 1'b0;
            sdata_o         <= 1'b0;
            sample_strobe_o <= 1'b0;
        end else begin
            div_cnt         <= div_cnt_nxt;
            slot            <= slot_nxt;
            shreg           <= shreg_nxt;
            word            <= word_nxt;
            bclk_o          <= bclk_nxt;
            lrclk_o         <= lrclk_nxt;
            sdata_o         <= sdata_nxt;
            sample_strobe_o <= strobe_nxt;
        end
    end

endmodule
